// File: rtl/reg_rx_fifo_if.sv
// Handshake bundle between the upstream register stage, reg_rx_fifo and its consumer.
// The master side drives the incoming word and the consumer's ready; the slave is the FIFO.
interface reg_rx_fifo_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/reg_rx_fifo.sv
// Receive FIFO for a no-backpressure valid-qualified word stream; overflowing words are dropped.
// Define REG_RX_STATS_EN to add saturating accepted/dropped word counters.
module reg_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    reg_rx_fifo_if.slave             bus,
    input  logic                     clr_ovf_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     overflow_o
`ifdef REG_RX_STATS_EN
    ,
    output logic [15:0]              acc_cnt_o,
    output logic [15:0]              drop_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             notEmpty, isFull, push, pop, drop;

    // Handshake decode: a pop in the same cycle frees the slot a full FIFO needs.
    always_comb begin
        notEmpty = (count_q != '0);
        isFull   = (count_q == CNT_W'(DEPTH));
        pop      = notEmpty & bus.out_ready;
        push     = bus.in_valid & (~isFull | pop);
        drop     = bus.in_valid & isFull & ~pop;
    end

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
        if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        if (clr_ovf_i) overflow_d = 1'b0;
        if (drop)      overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately unreset; out_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= bus.in_data;
    end

    assign bus.out_valid = notEmpty;
    assign bus.out_data  = notEmpty ? mem_q[rdPtr_q] : '0;
    assign count_o       = count_q;
    assign full_o        = isFull;
    assign overflow_o    = overflow_q;

`ifdef REG_RX_STATS_EN
    logic [15:0] accCnt_q, accCnt_d;
    logic [15:0] dropCnt_q, dropCnt_d;

    // A drop coinciding with a clear is still counted, matching the sticky flag's set-wins rule.
    always_comb begin
        accCnt_d  = accCnt_q;
        dropCnt_d = dropCnt_q;
        if (push && accCnt_q != 16'hFFFF) accCnt_d = accCnt_q + 16'd1;
        if (clr_ovf_i)                         dropCnt_d = drop ? 16'd1 : 16'd0;
        else if (drop && dropCnt_q != 16'hFFFF) dropCnt_d = dropCnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accCnt_q  <= '0;
            dropCnt_q <= '0;
        end else begin
            accCnt_q  <= accCnt_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    assign acc_cnt_o  = accCnt_q;
    assign drop_cnt_o = dropCnt_q;
`endif

endmodule

// File: doc/reg_rx_fifo.md
# reg_rx_fifo

Receive-side buffer for the pipeline's valid-qualified register interface. The upstream stage drives a 32-bit data word with a single-cycle `valid` qualifier and applies no backpressure. This block captures every valid word into a small FIFO and presents it to the downstream consumer over a valid/ready handshake. Words that arrive when the buffer cannot accept them are dropped and flagged with a sticky error.

## Interface
Parameters:
- `WIDTH`, 32, data word width.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `in_data`  in  WIDTH  word from upstream register stage
- `in_valid`  in  1  `in_data` is valid this cycle; one word per cycle high
- `out_data`  out  WIDTH  head-of-FIFO word; 0 when empty
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head this cycle
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `full`  out  1  count == DEPTH
- `overflow`  out  1  sticky; a word was dropped
- `clr_ovf`  in  1  synchronous clear of `overflow`
- `acc_cnt`  out  16  accepted-word counter (only with `REG_RX_STATS_EN`)
- `drop_cnt`  out  16  dropped-word counter (only with `REG_RX_STATS_EN`)

## Operation
- pop = `out_valid` & `out_ready`.
- push = `in_valid` & (~`full` | pop).
- drop = `in_valid` & `full` & ~pop.
- Push writes `in_data` at `wr_ptr` and advances `wr_ptr`. Pop advances `rd_ptr`. Both pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or on neither.
- Push and pop together when full: the word is accepted, `count` stays DEPTH, and no drop occurs.
- Push and pop together when count == 1: the head is popped, the new word becomes head next cycle, and `out_valid` stays 1.
- Push when empty: no same-cycle bypass. The word appears at the output the next cycle.
- Drop: the word is discarded, storage and pointers are unchanged, and `overflow` is set the next cycle.
- `clr_ovf` clears `overflow` the next cycle. If `clr_ovf` and drop occur in the same cycle, set wins and `overflow` is 1.
- `out_valid` = (`count` != 0).
- `out_data` = mem[`rd_ptr`] when `out_valid`, else 0. This is combinational from registered state.
- `out_ready` while empty has no effect.

## Timing
- Reset (`rst` low, asynchronous) sets `wr_ptr`, `rd_ptr`, `count`, `overflow`, `acc_cnt` and `drop_cnt` to 0.
- Reset outputs: `out_valid` = 0, `out_data` = 0, `full` = 0.
- Storage array is not reset. It is never observable because `out_data` is masked when empty.
- Reset mid-operation discards all buffered words immediately. The first edge after `rst` rises behaves as from empty.
- Latency: a word pushed at edge N is on `out_data` with `out_valid` = 1 after edge N (visible in cycle N+1) if the FIFO was empty.
- Throughput: one push and one pop per cycle sustained at any occupancy.
- All state updates on posedge `clk`. No combinational path from `in_valid` or `in_data` to any output.

## Configuration
- `REG_RX_STATS_EN` defined:
  - `acc_cnt` increments on each push.
  - `drop_cnt` increments on each drop.
  - Both are 16-bit, saturate at 16'hFFFF, and are reset to 0.
  - `clr_ovf` also clears `drop_cnt`. `acc_cnt` is not cleared by `clr_ovf`.
- Not defined: the `acc_cnt` and `drop_cnt` ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset, then push 32'hDEADBEEF for one cycle with `out_ready` = 0 → next cycle `out_valid` = 1, `out_data` = 32'hDEADBEEF, `count` = 1.
- Push 4 words 1,2,3,4 back-to-back with `out_ready` = 0 → `full` = 1, `count` = 4. Then push 5 with `out_ready` still 0 → `overflow` = 1 next cycle, `count` = 4; draining yields 1,2,3,4 only (`drop_cnt` = 1 with stats).
- While full, push 5 with `out_ready` = 1 in the same cycle → 1 pops, 5 accepted, `count` stays 4, `overflow` stays 0; drain order 2,3,4,5.
- Continuous push 0..19 with `out_ready` = 1 every cycle → `count` never exceeds 1; outputs 0..19 in order, each one cycle after its push; pointers wrap with no loss.
- Assert drop and `clr_ovf` in the same cycle → `overflow` = 1. Assert `clr_ovf` alone next cycle → `overflow` = 0.
- With 3 words buffered, pulse `rst` low mid-cycle → immediately `out_valid` = 0, `out_data` = 0, `count` = 0, `overflow` = 0.
